// File: rtl/sreg_ctrl_pkg.sv
// Shared types for the shift-register sequencer: job modes and the FSM state encoding.
package sreg_ctrl_pkg;

  localparam logic MODE_SIPO = 1'b0;
  localparam logic MODE_SISO = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4,
    RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Arbitrates only while i_en is high; on a tie the
// requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic       o_grant,
  output logic       o_winner
);

  logic r_last;
  logic w_winner;

  always_comb begin
    w_winner = 1'b0;
    case (i_req)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last;
      default: w_winner = 1'b0;
    endcase
  end

  assign o_grant  = i_en & (|i_req);
  assign o_winner = w_winner;

  // r_last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (o_grant) begin
      r_last <= w_winner;
    end
  end

endmodule

// File: rtl/sreg_seq_ctrl.sv
// Sequencer for a 4-bit SIPO/SISO shift register shared by two requesters.
// Handshakes: reqN_ready is a 1-cycle accept pulse while reqN_valid is high in IDLE;
// rsp_valid holds with stable rsp_id/rsp_data until the cycle rsp_valid && rsp_ready.
module sreg_seq_ctrl
  import sreg_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             sr_choice,
  output logic             sr_resetsi,
  output logic             sr_resetpo,
  output logic             sr_sinp,
  input  logic [WIDTH-1:0] sr_pout,
  input  logic             sr_sout,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_mode;
  logic             r_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             w_en;
  logic             w_grant;
  logic             w_winner;

  assign w_en = (r_state == IDLE) && !reset;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_en),
    .i_req    ({req1_valid, req0_valid}),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    sr_choice  = 1'b0;
    sr_resetsi = 1'b1;
    sr_resetpo = 1'b1;
    sr_sinp    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          req0_ready = ~w_winner;
          req1_ready = w_winner;
          w_next     = CLEAR;
        end
      end
      CLEAR: begin
        sr_choice = r_mode;
        w_next    = SHIFT;
      end
      SHIFT: begin
        sr_choice  = r_mode;
        sr_resetsi = (r_mode == MODE_SISO);
        sr_resetpo = (r_mode == MODE_SIPO);
        sr_sinp    = r_data[WIDTH-1];
        if (r_cnt == SHIFT_LAST) begin
          w_next = (r_mode == MODE_SISO) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        sr_choice  = r_mode;
        sr_resetsi = 1'b0;
        w_next     = RESP;
      end
      DRAIN: begin
        // WIDTH sampling cycles plus one trailing cycle before the response.
        sr_choice  = r_mode;
        sr_resetpo = 1'b0;
        if (r_cnt == DRAIN_LAST) begin
          w_next = RESP;
        end
      end
      RESP: begin
        sr_choice = r_mode;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_mode     <= MODE_SIPO;
      r_id       <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state == SHIFT || r_state == DRAIN) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == IDLE && w_grant) begin
        r_data <= w_winner ? req1_data : req0_data;
        r_mode <= w_winner ? req1_mode : req0_mode;
        r_id   <= w_winner;
      end else if (r_state == SHIFT) begin
        r_data <= r_data << 1;
      end
      if (r_state == CAPTURE) begin
        r_rsp_data <= sr_pout;
      end else if (r_state == DRAIN && r_cnt < DRAIN_LAST) begin
        r_rsp_data <= {r_rsp_data[WIDTH-2:0], sr_sout};
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign dbg_state = r_state;

endmodule
